// File: rtl/dest_reg_pipe.sv
// Destination-register tracking pipeline: picks one candidate destination per
// instruction, carries it through DEPTH stages and reports operand forwarding hits.
module dest_reg_pipe #(
  parameter  int AW    = 5,
  parameter  int NSRC  = 3,
  parameter  int DEPTH = 3,
  localparam int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*AW-1:0]    src_addr,
  input  logic [SW-1:0]         sel,
  input  logic                  valid_in,
  input  logic                  wr_in,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [AW-1:0]         rs_addr,
  input  logic [AW-1:0]         rt_addr,
  output logic [DEPTH*AW-1:0]   dst_addr,
  output logic [DEPTH-1:0]      dst_wr,
  output logic                  rs_fwd_vld,
  output logic                  rt_fwd_vld,
  output logic [2:0]            rs_fwd_stg,
  output logic [2:0]            rt_fwd_stg
);

  logic [AW-1:0] sel_addr;
  logic          sel_ok;

  // Out-of-range select yields address 0 and no write.
  always_comb begin
    sel_addr = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SW'(k)) begin
        sel_addr = src_addr[k*AW +: AW];
        sel_ok   = 1'b1;
      end
    end
  end

  // feed[i] is what stage i loads on an advancing edge; feed[0] is the new instruction.
  logic [DEPTH:0]          feed_valid;
  logic [DEPTH:0]          feed_wr;
  logic [(DEPTH+1)*AW-1:0] feed_addr;

  assign feed_valid[0]       = valid_in;
  assign feed_wr[0]          = wr_in & sel_ok;
  assign feed_addr[0 +: AW]  = sel_addr;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
      logic          valid_q;
      logic          wr_q;
      logic [AW-1:0] addr_q;

      // Flush bubbles only the head stage; later stages still obey hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
        end else if (flush && (gi == 0)) begin
          valid_q <= 1'b0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
        end else if (!hold) begin
          valid_q <= feed_valid[gi];
          wr_q    <= feed_wr[gi];
          addr_q  <= feed_addr[gi*AW +: AW];
        end
      end

      assign feed_valid[gi+1]          = valid_q;
      assign feed_wr[gi+1]             = wr_q;
      assign feed_addr[(gi+1)*AW +: AW] = addr_q;

      assign dst_addr[gi*AW +: AW] = addr_q;
      assign dst_wr[gi]            = valid_q & wr_q & (addr_q != '0);
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    rs_fwd_vld = 1'b0;
    rs_fwd_stg = 3'd0;
    rt_fwd_vld = 1'b0;
    rt_fwd_stg = 3'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (dst_wr[i] && (dst_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0)) begin
        rs_fwd_vld = 1'b1;
        rs_fwd_stg = 3'(i);
      end
      if (dst_wr[i] && (dst_addr[i*AW +: AW] == rt_addr) && (rt_addr != '0)) begin
        rt_fwd_vld = 1'b1;
        rt_fwd_stg = 3'(i);
      end
    end
  end

endmodule
